// File: rtl/game_event_reporter.sv
// Frame-synchronous game event encoder for the frog game: queues collision/landing/frog-change
// events in a FIFO that Nios software drains over an Avalon-MM slave.
module game_event_reporter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [3:0]  Car_Collision,
  input  logic [3:0]  LPad_Collision,
  input  logic [2:0]  Frog_Sel,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic             r_fs1, r_fs2, r_fd;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_ovf;
  logic [3:0]       r_prev_car, r_prev_lpad;
  logic [2:0]       r_prev_sel;
  logic             r_primed;
  logic             r_irq_en;
  logic             r_irq;
  logic [31:0]      r_readdata;
  ptr_t             r_wr, r_rd;
  logic [31:0]      r_mem [DEPTH];

  logic             w_tick;
  logic [CNT_W-1:0] w_frame_nxt;
  logic [31:0]      w_event;
  ptr_t             w_level;
  logic             w_full, w_empty;
  logic             w_clear, w_pop, w_push_req, w_push, w_ovf_inc;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_unused = ^avs_writedata[31:2];

  assign w_tick      = r_fs2 & ~r_fd;
  assign w_frame_nxt = r_frame_cnt + CNT_W'(1);

  assign w_event = {16'(w_frame_nxt), 4'b0000,
                    Car_Collision & ~r_prev_car,
                    LPad_Collision & ~r_prev_lpad,
                    (Frog_Sel != r_prev_sel),
                    Frog_Sel};

  assign w_level = r_wr - r_rd;
  assign w_full  = (w_level == ptr_t'(DEPTH));
  assign w_empty = (w_level == '0);

  // Clear outranks every pointer move; a dropped push during clear is not an overflow.
  assign w_clear    = avs_write & (avs_address == 2'd3) & avs_writedata[1];
  assign w_pop      = avs_read & (avs_address == 2'd0) & ~w_empty & ~w_clear;
  assign w_push_req = w_tick & r_primed & (|w_event[11:3]);
  assign w_push     = w_push_req & (~w_full | w_pop) & ~w_clear;
  assign w_ovf_inc  = w_push_req & w_full & ~w_pop & ~w_clear;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      2'd0:    if (!w_empty) w_rdata = r_mem[r_rd[AW-1:0]];
      2'd1:    w_rdata = {16'(r_ovf), 8'(w_level), 6'b000000, w_full, w_empty};
      2'd2:    w_rdata = {16'h0000, 16'(r_frame_cnt)};
      default: w_rdata = {31'b0, r_irq_en};
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs1       <= 1'b0;
      r_fs2       <= 1'b0;
      r_fd        <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf       <= '0;
      r_prev_car  <= '0;
      r_prev_lpad <= '0;
      r_prev_sel  <= '0;
      r_primed    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
    end else begin
      r_fs1 <= frame_clk;
      r_fs2 <= r_fs1;
      r_fd  <= r_fs2;
      r_irq <= r_irq_en & ~w_empty;

      if (w_tick) begin
        r_frame_cnt <= w_frame_nxt;
        r_prev_car  <= Car_Collision;
        r_prev_lpad <= LPad_Collision;
        r_prev_sel  <= Frog_Sel;
      end

      if (avs_read) r_readdata <= w_rdata;
      if (avs_write && avs_address == 2'd3) r_irq_en <= avs_writedata[0];

      if (w_clear) begin
        r_wr     <= '0;
        r_rd     <= '0;
        r_ovf    <= '0;
        r_primed <= 1'b0;
      end else begin
        if (w_tick) r_primed <= 1'b1;
        if (w_push) r_wr <= r_wr + ptr_t'(1);
        if (w_pop)  r_rd <= r_rd + ptr_t'(1);
        if (w_ovf_inc && r_ovf != '1) r_ovf <= r_ovf + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= w_event;
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;

endmodule
